// File: rtl/spi_cfg_sequencer.sv
// spi_cfg_sequencer: walks a ROM command table and drives a single-transaction SPI engine
module spi_cfg_sequencer #(
  parameter int SPI_INFO_LENGTH = 8,
  parameter int SPI_DATA_LENGTH = 8,
  parameter int ADDR_W = 6,
  parameter int TIMEOUT_CLKS = 4096
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic i_start,
  output logic o_busy,
  output logic o_done,
  output logic o_error,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [SPI_INFO_LENGTH+SPI_DATA_LENGTH+1:0] i_rom_data,
  output logic [1:0] o_wrrd_mode_sel,
  output logic [SPI_INFO_LENGTH+SPI_DATA_LENGTH-1:0] o_wr_infodata,
  output logic [SPI_INFO_LENGTH-1:0] o_rd_info,
  output logic [15:0] o_delay_cnt,
  output logic o_datain_valid,
  input  logic i_datain_ready,
  input  logic i_r_sclk,
  input  logic i_cs_n,
  input  logic [SPI_DATA_LENGTH-1:0] i_rd_data,
  output logic [SPI_DATA_LENGTH-1:0] o_rd_data_last,
  output logic [7:0] o_mismatch_cnt,
  output logic [ADDR_W-1:0] o_cmd_idx
);
  localparam int PL_W = SPI_INFO_LENGTH + SPI_DATA_LENGTH;
  localparam int CMD_W = PL_W + 2;
  localparam int TMR_W = $clog2(TIMEOUT_CLKS + 1);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, ISSUE, WAIT_DONE, DONE, ERROR} state_t;
  state_t st, nxt;
  logic [1:0] w_mode;
  logic [PL_W-1:0] w_pl;
  logic [SPI_DATA_LENGTH-1:0] exp_data;
  logic [TMR_W-1:0] tmr;
  logic [16:0] ecnt;
  logic sclk_q, cs_q, rdy_seen, cs_seen;
  logic sclk_rise, cs_rise, tmo, fin;
  assign w_mode = i_rom_data[CMD_W-1:CMD_W-2];
  assign w_pl = i_rom_data[PL_W-1:0];
  assign sclk_rise = i_r_sclk & ~sclk_q;
  assign cs_rise = i_cs_n & ~cs_q & cs_seen;
  assign tmo = tmr == TMR_W'(TIMEOUT_CLKS - 1);
  assign fin = o_wrrd_mode_sel == 2'b10 ? ecnt >= {1'b0, o_delay_cnt} + 17'd3 : cs_rise;
  assign o_busy = st inside {FETCH, LOAD, ISSUE, WAIT_DONE};
  assign o_done = st == DONE || st == ERROR;
  assign o_cmd_idx = o_rom_addr;
  // state register
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else st <= nxt;
  // next state: the last table slot may not complete without an END marker
  always_comb begin
    nxt = st;
    case (st)
      IDLE: nxt = i_start ? FETCH : IDLE;
      FETCH: nxt = LOAD;
      LOAD: nxt = ISSUE;
      ISSUE: nxt = o_wrrd_mode_sel == 2'b11 ? DONE : tmo ? ERROR : rdy_seen && sclk_rise ? WAIT_DONE : ISSUE;
      WAIT_DONE: nxt = tmo ? ERROR : !fin ? WAIT_DONE : &o_rom_addr ? ERROR : FETCH;
      default: nxt = IDLE;
    endcase
  end
  // datapath: engine inputs load only in LOAD, handshake/completion tracking, read-back compare
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) begin
      o_error <= 1'b0;
      o_rom_addr <= '0;
      o_wrrd_mode_sel <= '0;
      o_wr_infodata <= '0;
      o_rd_info <= '0;
      o_delay_cnt <= '0;
      o_datain_valid <= 1'b0;
      o_rd_data_last <= '0;
      o_mismatch_cnt <= '0;
      exp_data <= '0;
      tmr <= '0;
      ecnt <= '0;
      sclk_q <= 1'b0;
      cs_q <= 1'b1;
      rdy_seen <= 1'b0;
      cs_seen <= 1'b0;
    end else begin
      sclk_q <= i_r_sclk;
      cs_q <= i_cs_n;
      tmr <= (nxt != st || !(st inside {ISSUE, WAIT_DONE})) ? '0 : tmr + 1'b1;
      o_datain_valid <= nxt == ISSUE && !(st == LOAD && w_mode == 2'b11);
      if (st == IDLE && i_start) begin
        o_rom_addr <= '0;
        o_error <= 1'b0;
        o_mismatch_cnt <= '0;
      end
      if (nxt == ERROR) o_error <= 1'b1;
      if (st == WAIT_DONE && nxt == FETCH) o_rom_addr <= o_rom_addr + 1'b1;
      if (st == LOAD) begin
        o_wrrd_mode_sel <= w_mode;
        rdy_seen <= 1'b0;
        cs_seen <= 1'b0;
        ecnt <= '0;
        if (w_mode == 2'b00) o_wr_infodata <= w_pl;
        if (w_mode == 2'b01) begin
          o_rd_info <= w_pl[PL_W-1:SPI_DATA_LENGTH];
          exp_data <= w_pl[SPI_DATA_LENGTH-1:0];
        end
        if (w_mode == 2'b10) o_delay_cnt <= 16'(w_pl);
      end
      if (st == ISSUE && i_datain_ready) rdy_seen <= 1'b1;
      if (st inside {ISSUE, WAIT_DONE}) begin
        if (!i_cs_n) cs_seen <= 1'b1;
        if (sclk_rise && (rdy_seen || i_datain_ready)) ecnt <= ecnt + 1'b1;
      end
      if (st == WAIT_DONE && o_wrrd_mode_sel == 2'b01 && cs_rise) begin
        o_rd_data_last <= i_rd_data;
        if (i_rd_data != exp_data && o_mismatch_cnt != 8'hFF) o_mismatch_cnt <= o_mismatch_cnt + 1'b1;
      end
    end
endmodule
